mcb_port_responder: RTL and testbench
=====================================

Name: mcb_port_responder

Overview:
- Synthesizable responder for the far side of the 32-bit memory user port (p0 command, write-data and read-data channels) that ddr2_state_machine drives.
- Backs the port with on-chip block RAM and models the calibration delay, so the write/read streaming path can be brought up and simulated without the SDRAM controller.
- Sits in place of the memory controller port: `calib_done` and all p0 status outputs originate here.

Parameters:
- ADDR_W, 12: word-address width; backing store depth is 2^ADDR_W 32-bit words.
- CALIB_CYCLES, 64: cycles after reset release before `calib_done` rises; 16-bit counter.
- CMD_DEPTH, 4: command FIFO depth (power of two).
- DATA_DEPTH, 64: write-data and read-data FIFO depth (power of two, at least 64).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- calib_done  out  1  high once the calibration delay has elapsed
- p0_cmd_en  in  1  push command
- p0_cmd_instr  in  3  000 wr, 001 rd, 010 wr-ap, 011 rd-ap, others no-op
- p0_cmd_byte_addr  in  30  byte address of the first word
- p0_cmd_bl  in  6  burst length minus 1
- p0_cmd_full  out  1  command FIFO full
- p0_wr_en  in  1  push write word
- p0_wr_data  in  32  write word
- p0_wr_mask  in  4  byte mask, 1 = do not write that byte
- p0_wr_full  out  1  write-data FIFO full
- p0_wr_underrun  out  1  sticky error flag
- p0_rd_en  in  1  pop read word
- p0_rd_data  out  32  head of read FIFO, first-word-fall-through
- p0_rd_empty  out  1  read FIFO empty
- p0_rd_overflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset values:
  - All outputs 0, except `p0_rd_empty` = 1.
  - All FIFOs emptied; state machine in S_CALIB; calibration counter = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation aborts any burst immediately. Partial writes already committed to RAM remain.
- Calibration:
  - S_CALIB counts up to CALIB_CYCLES-1, then `calib_done` goes high on the next edge and the state moves to S_IDLE.
  - `calib_done` stays high until reset.
  - Pushes before `calib_done` are accepted into the FIFOs but not executed.
- Channel pushes and pops:
  - Command push when `p0_cmd_en` and not full. A push while full is dropped.
  - Write-data push when `p0_wr_en` and not full. A push while full is dropped.
  - A read pop while empty is ignored and sets `p0_rd_overflow`.
  - All three FIFOs support a simultaneous push and pop in the same cycle.
- Address arithmetic:
  - word address = `p0_cmd_byte_addr[ADDR_W+1:2]`; bits [1:0] are ignored.
  - The address increments by 1 per beat and wraps modulo 2^ADDR_W.
- S_IDLE: if the command FIFO is non-empty, pop it, latch instr, address and beat count = bl+1, then branch:
  - write or wr-ap: go to S_WRITE.
  - read or rd-ap: go to S_READ.
  - other instr: consumed, stay in S_IDLE.
- S_WRITE:
  - Each cycle the write-data FIFO is non-empty: pop one word and write it to RAM with per-byte enables = ~mask. Then increment the address and decrement the beat count.
  - Return to S_IDLE after the last beat.
  - If the write-data FIFO is empty while beats remain: stall and set `p0_wr_underrun`.
- S_READ:
  - Issue one RAM read per cycle while read-FIFO free space exceeds the number of words in flight.
  - RAM read latency is 1 cycle; the returned word is pushed into the read FIFO.
  - Go to S_IDLE once all bl+1 words have been pushed.
  - Overflow of the read FIFO is impossible by construction.
- Latency: a read command pushed at cycle T, with the responder idle, produces `p0_rd_empty` = 0 at T+4.
- Ordering: a read issued after a write to the same address returns the new data, because commands execute strictly in order.

Optional Feature:
- Macro: MCB_RESP_STATS_EN.
- When defined:
  - Adds outputs `wr_cmd_count` [15:0] and `rd_cmd_count` [15:0].
  - Each increments by 1 per executed write/read command, saturates at 16'hFFFF, and resets to 0.
- When undefined: the ports and counters are absent.

Decomposition:
- Package `mcb_resp_pkg`:
  - Instruction codes INSTR_WR=3'b000, INSTR_RD=3'b001, INSTR_WR_AP=3'b010, INSTR_RD_AP=3'b011.
  - State encodings S_CALIB, S_IDLE, S_WRITE, S_READ.
- Sub-module `mcb_resp_fifo`:
  - Parameterized width/depth, FWFT, with full/empty/count outputs.
  - Instantiated three times: command, write data, read data.

Test Plan:
- Hold reset low 5 cycles, then release -> `calib_done` = 0 for 64 cycles and 1 from cycle 65; `p0_rd_empty` = 1 throughout.
- Push wr data 32'hA5A5_0001, 32'hA5A5_0002, then cmd wr, addr 0, bl 1; then cmd rd, addr 0, bl 1 -> `p0_rd_data` returns 0001 then 0002, in order, with correct empty timing.
- Write 32'hFFFF_FFFF to addr 8, then write 32'h1234_5678 with mask 4'b0101 to addr 8, then read -> 32'h12FF_56FF.
- Cmd wr, bl 3, with only 2 data words pushed -> stall and `p0_wr_underrun` = 1; push 2 more words -> completes; a read of that burst returns all 4 words.
- Write at byte addr (2^12-1)*4, bl 1 -> second word lands at word 0 (wrap); readback confirms.
- Fill the read FIFO with 64 words without popping, then issue a further rd bl 1 -> no words lost; after 2 pops, both words appear. A pop while empty -> `p0_rd_overflow` = 1.

Source files
------------

// File: rtl/mcb_resp_pkg.sv
// Shared definitions for the memory-port responder: instruction codes,
// sequencer states and small decode helpers.
package mcb_resp_pkg;

    localparam logic [2:0] INSTR_WR    = 3'b000;
    localparam logic [2:0] INSTR_RD    = 3'b001;
    localparam logic [2:0] INSTR_WR_AP = 3'b010;
    localparam logic [2:0] INSTR_RD_AP = 3'b011;

    typedef enum logic [1:0] {
        S_CALIB = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_e;

    function automatic logic instr_is_write(input logic [2:0] instr);
        return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
    endfunction

    function automatic logic instr_is_read(input logic [2:0] instr);
        return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
    endfunction

endpackage

// File: rtl/mcb_resp_fifo.sv
// First-word-fall-through FIFO with full/empty/count; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module mcb_resp_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head is forced to zero while empty so the output never shows stale storage.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM backed responder for the 32-bit p0 memory user port, with calibration delay.
// Optional per-command statistics counters are enabled by defining MCB_RESP_STATS_EN.
module mcb_port_responder
    import mcb_resp_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int CALIB_CYCLES = 64,
    parameter int CMD_DEPTH    = 4,
    parameter int DATA_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        calib_done,
    input  logic        p0_cmd_en,
    input  logic [2:0]  p0_cmd_instr,
    input  logic [29:0] p0_cmd_byte_addr,
    input  logic [5:0]  p0_cmd_bl,
    output logic        p0_cmd_full,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_wr_data,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_wr_full,
    output logic        p0_wr_underrun,
    input  logic        p0_rd_en,
    output logic [31:0] p0_rd_data,
    output logic        p0_rd_empty,
    output logic        p0_rd_overflow
`ifdef MCB_RESP_STATS_EN
    ,
    output logic [15:0] wr_cmd_count,
    output logic [15:0] rd_cmd_count
`endif
);

    localparam int CMD_W  = 3 + ADDR_W + 6;
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int DAT_CW = $clog2(DATA_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [15:0]         calib_cnt_q, calib_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [6:0]          beats_q, beats_d;
    logic                ram_valid_q, ram_valid_d;
    logic                wr_underrun_q, wr_underrun_d;
    logic                rd_overflow_q, rd_overflow_d;

    logic                cmd_pop, cmd_empty;
    logic [CMD_W-1:0]    cmd_head;
    logic [CMD_CW-1:0]   cmd_count;
    logic [2:0]          head_instr;
    logic [ADDR_W-1:0]   head_addr;
    logic [5:0]          head_bl;

    logic                wr_pop, wr_empty;
    logic [35:0]         wr_head;
    logic [DAT_CW-1:0]   wr_count;
    logic [31:0]         wr_word;
    logic [3:0]          wr_word_mask;

    logic                rd_full;
    logic [DAT_CW-1:0]   rd_count;
    logic [DAT_CW-1:0]   rd_free;
    logic                rd_issue;
    logic                ram_we;
    logic [31:0]         ram_q [2**ADDR_W];
    logic [31:0]         ram_rdata_q;
    logic                unused_bits;

    assign unused_bits = ^{p0_cmd_byte_addr[29:ADDR_W+2], p0_cmd_byte_addr[1:0],
                           cmd_count, wr_count, rd_full};

    mcb_resp_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (p0_cmd_en),
        .push_data ({p0_cmd_instr, p0_cmd_byte_addr[ADDR_W+1:2], p0_cmd_bl}),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (p0_cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    mcb_resp_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (p0_wr_en),
        .push_data ({p0_wr_mask, p0_wr_data}),
        .pop       (wr_pop),
        .pop_data  (wr_head),
        .full      (p0_wr_full),
        .empty     (wr_empty),
        .count     (wr_count)
    );

    mcb_resp_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ram_valid_q),
        .push_data (ram_rdata_q),
        .pop       (p0_rd_en),
        .pop_data  (p0_rd_data),
        .full      (rd_full),
        .empty     (p0_rd_empty),
        .count     (rd_count)
    );

    assign head_instr   = cmd_head[CMD_W-1 -: 3];
    assign head_addr    = cmd_head[6 +: ADDR_W];
    assign head_bl      = cmd_head[5:0];
    assign wr_word      = wr_head[31:0];
    assign wr_word_mask = wr_head[35:32];
    // A read is only issued when the FIFO can absorb it plus the word already in flight.
    assign rd_free      = DAT_CW'(DATA_DEPTH) - rd_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_CALIB;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        calib_cnt_d = calib_cnt_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        unique case (state_q)
            S_CALIB: begin
                if (calib_cnt_q == 16'(CALIB_CYCLES - 1)) state_d = S_IDLE;
                else                                      calib_cnt_d = calib_cnt_q + 16'd1;
            end
            S_IDLE: begin
                if (!cmd_empty) begin
                    addr_d  = head_addr;
                    beats_d = {1'b0, head_bl} + 7'd1;
                    if (instr_is_write(head_instr))     state_d = S_WRITE;
                    else if (instr_is_read(head_instr)) state_d = S_READ;
                end
            end
            S_WRITE: begin
                if (!wr_empty) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - 7'd1;
                    if (beats_q == 7'd1) state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - 7'd1;
                end
                if ((beats_q == 7'd0) && ram_valid_q) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_pop  = 1'b0;
        wr_pop   = 1'b0;
        ram_we   = 1'b0;
        rd_issue = 1'b0;
        unique case (state_q)
            S_CALIB: ;
            S_IDLE:  cmd_pop = !cmd_empty;
            S_WRITE: begin
                wr_pop = !wr_empty;
                ram_we = !wr_empty;
            end
            S_READ:  rd_issue = (beats_q != 7'd0) && (rd_free > DAT_CW'(ram_valid_q));
        endcase
    end

    assign calib_done     = (state_q != S_CALIB);
    assign p0_wr_underrun = wr_underrun_q;
    assign p0_rd_overflow = rd_overflow_q;

    always_comb begin
        ram_valid_d   = rd_issue;
        wr_underrun_d = wr_underrun_q | ((state_q == S_WRITE) && wr_empty);
        rd_overflow_d = rd_overflow_q | (p0_rd_en && p0_rd_empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            calib_cnt_q   <= '0;
            addr_q        <= '0;
            beats_q       <= '0;
            ram_valid_q   <= 1'b0;
            wr_underrun_q <= 1'b0;
            rd_overflow_q <= 1'b0;
        end else begin
            calib_cnt_q   <= calib_cnt_d;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            ram_valid_q   <= ram_valid_d;
            wr_underrun_q <= wr_underrun_d;
            rd_overflow_q <= rd_overflow_d;
        end
    end

    // Backing store is not reset; byte lanes with mask bit set keep their old value.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_word_mask[b]) ram_q[addr_q][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
        if (rd_issue) ram_rdata_q <= ram_q[addr_q];
    end

`ifdef MCB_RESP_STATS_EN
    logic [15:0] wr_cmd_count_q, wr_cmd_count_d;
    logic [15:0] rd_cmd_count_q, rd_cmd_count_d;

    always_comb begin
        wr_cmd_count_d = wr_cmd_count_q;
        rd_cmd_count_d = rd_cmd_count_q;
        if ((state_q == S_IDLE) && !cmd_empty) begin
            if (instr_is_write(head_instr) && (wr_cmd_count_q != 16'hFFFF))
                wr_cmd_count_d = wr_cmd_count_q + 16'd1;
            if (instr_is_read(head_instr) && (rd_cmd_count_q != 16'hFFFF))
                rd_cmd_count_d = rd_cmd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cmd_count_q <= '0;
            rd_cmd_count_q <= '0;
        end else begin
            wr_cmd_count_q <= wr_cmd_count_d;
            rd_cmd_count_q <= rd_cmd_count_d;
        end
    end

    assign wr_cmd_count = wr_cmd_count_q;
    assign rd_cmd_count = rd_cmd_count_q;
`endif

endmodule

// File: tb/tb_mcb_port_responder.sv
// Self-checking bench for mcb_port_responder: directed scenarios plus randomized
// command streams checked against a word/byte-level memory model and an expected-read queue.
module tb_mcb_port_responder;

    localparam int WORDS = 4096;
    localparam logic [2:0] I_WR    = 3'b000;
    localparam logic [2:0] I_RD    = 3'b001;
    localparam logic [2:0] I_WR_AP = 3'b010;
    localparam logic [2:0] I_RD_AP = 3'b011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        calib_done;
    logic        p0_cmd_en = 1'b0;
    logic [2:0]  p0_cmd_instr = '0;
    logic [29:0] p0_cmd_byte_addr = '0;
    logic [5:0]  p0_cmd_bl = '0;
    logic        p0_cmd_full;
    logic        p0_wr_en = 1'b0;
    logic [31:0] p0_wr_data = '0;
    logic [3:0]  p0_wr_mask = '0;
    logic        p0_wr_full;
    logic        p0_wr_underrun;
    logic        p0_rd_en = 1'b0;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;
    logic        p0_rd_overflow;
`ifdef MCB_RESP_STATS_EN
    logic [15:0] wr_cmd_count;
    logic [15:0] rd_cmd_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [WORDS];
    bit          model_known [WORDS];
    logic [31:0] exp_q [$];
    logic [31:0] wbuf_data [64];
    logic [3:0]  wbuf_mask [64];
    int          last_wr_addr = 0;
    int          last_wr_n = 0;

    always #5 clk = ~clk;

    mcb_port_responder dut (
        .clk              (clk),
        .reset            (reset),
        .calib_done       (calib_done),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_bl        (p0_cmd_bl),
        .p0_cmd_full      (p0_cmd_full),
        .p0_wr_en         (p0_wr_en),
        .p0_wr_data       (p0_wr_data),
        .p0_wr_mask       (p0_wr_mask),
        .p0_wr_full       (p0_wr_full),
        .p0_wr_underrun   (p0_wr_underrun),
        .p0_rd_en         (p0_rd_en),
        .p0_rd_data       (p0_rd_data),
        .p0_rd_empty      (p0_rd_empty),
        .p0_rd_overflow   (p0_rd_overflow)
`ifdef MCB_RESP_STATS_EN
        ,
        .wr_cmd_count     (wr_cmd_count),
        .rd_cmd_count     (rd_cmd_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        int guard = 0;
        while (p0_wr_full && guard < 500) begin
            tick();
            guard++;
        end
        if (p0_wr_full) begin
            checks++;
            failures++;
            $display("[TB] FAIL wr_full_timeout got=full required=space");
        end
        p0_wr_en   = 1'b1;
        p0_wr_data = d;
        p0_wr_mask = m;
        tick();
        p0_wr_en   = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [29:0] baddr, input logic [5:0] bl);
        int guard = 0;
        while (p0_cmd_full && guard < 500) begin
            tick();
            guard++;
        end
        if (p0_cmd_full) begin
            checks++;
            failures++;
            $display("[TB] FAIL cmd_full_timeout got=full required=space");
        end
        p0_cmd_en        = 1'b1;
        p0_cmd_instr     = instr;
        p0_cmd_byte_addr = baddr;
        p0_cmd_bl        = bl;
        tick();
        p0_cmd_en        = 1'b0;
    endtask

    function automatic logic [29:0] byte_addr_of(input int waddr, input bit noisy);
        logic [29:0] a;
        a = {16'h0000, 12'(waddr), 2'b00};
        if (noisy) a = {16'($urandom), 12'(waddr), 2'($urandom)};
        return a;
    endfunction

    // Push n words from wbuf, issue the write command, and apply it to the model.
    task automatic do_write(input int waddr, input int n, input logic [2:0] instr, input bit noisy);
        for (int i = 0; i < n; i++) push_wr(wbuf_data[i], wbuf_mask[i]);
        push_cmd(instr, byte_addr_of(waddr, noisy), 6'(n - 1));
        for (int i = 0; i < n; i++) begin
            int a;
            a = (waddr + i) % WORDS;
            for (int b = 0; b < 4; b++)
                if (!wbuf_mask[i][b]) model_mem[a][8*b +: 8] = wbuf_data[i][8*b +: 8];
            model_known[a] = 1'b1;
        end
    endtask

    task automatic do_read(input int waddr, input int n, input logic [2:0] instr, input bit noisy);
        push_cmd(instr, byte_addr_of(waddr, noisy), 6'(n - 1));
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(waddr + i) % WORDS]);
    endtask

    task automatic pop_check(input string name);
        int guard = 0;
        logic [31:0] exp;
        exp = exp_q.pop_front();
        while (p0_rd_empty && guard < 300) begin
            tick();
            guard++;
        end
        checks++;
        if (p0_rd_empty) begin
            failures++;
            $display("[TB] FAIL %s rd_timeout got=empty required=%h", name, exp);
        end else begin
            if (p0_rd_data !== exp) begin
                failures++;
                $display("[TB] FAIL %s rd_data got=%h required=%h", name, p0_rd_data, exp);
            end
            p0_rd_en = 1'b1;
            tick();
            p0_rd_en = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_check(name);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if ({calib_done, p0_cmd_full, p0_wr_full, p0_wr_underrun, p0_rd_empty, p0_rd_overflow} !== 6'b000010) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b required=000010",
                     {calib_done, p0_cmd_full, p0_wr_full, p0_wr_underrun, p0_rd_empty, p0_rd_overflow});
        end
        checks++;
        if (p0_rd_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rd_data got=%h required=00000000", p0_rd_data);
        end
        reset = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            tick();
            checks++;
            if (calib_done !== (e >= 64) || p0_rd_empty !== 1'b1) begin
                failures++;
                $display("[TB] FAIL calib edge=%0d got calib_done=%b rd_empty=%b required=%b/1",
                         e, calib_done, p0_rd_empty, (e >= 64));
            end
        end
    endtask

    task automatic test_basic();
        wbuf_data[0] = 32'hA5A5_0001; wbuf_mask[0] = 4'b0000;
        wbuf_data[1] = 32'hA5A5_0002; wbuf_mask[1] = 4'b0000;
        do_write(0, 2, I_WR, 1'b0);
        do_read(0, 2, I_RD, 1'b0);
        drain("basic");
        tick();
        checks++;
        if (p0_rd_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_empty_after got=%b required=1", p0_rd_empty);
        end
    endtask

    task automatic test_mask();
        wbuf_data[0] = 32'hFFFF_FFFF; wbuf_mask[0] = 4'b0000;
        do_write(8, 1, I_WR, 1'b0);
        wbuf_data[0] = 32'h1234_5678; wbuf_mask[0] = 4'b0101;
        do_write(8, 1, I_WR_AP, 1'b0);
        do_read(8, 1, I_RD_AP, 1'b0);
        drain("mask");
    endtask

    task automatic test_latency();
        repeat (5) tick();
        p0_cmd_en        = 1'b1;
        p0_cmd_instr     = I_RD;
        p0_cmd_byte_addr = byte_addr_of(8, 1'b0);
        p0_cmd_bl        = 6'd0;
        exp_q.push_back(model_mem[8]);
        tick();
        p0_cmd_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            checks++;
            if (p0_rd_empty !== (k < 4)) begin
                failures++;
                $display("[TB] FAIL latency T+%0d rd_empty got=%b required=%b", k, p0_rd_empty, (k < 4));
            end
        end
        drain("latency");
    endtask

    task automatic test_underrun();
        checks++;
        if (p0_wr_underrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL underrun_pre got=%b required=0", p0_wr_underrun);
        end
        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = $urandom;
            wbuf_mask[i] = 4'b0000;
        end
        push_wr(wbuf_data[0], 4'b0000);
        push_wr(wbuf_data[1], 4'b0000);
        push_cmd(I_WR, byte_addr_of(64, 1'b0), 6'd3);
        for (int i = 0; i < 4; i++) begin
            model_mem[64 + i]   = wbuf_data[i];
            model_known[64 + i] = 1'b1;
        end
        repeat (10) tick();
        checks++;
        if (p0_wr_underrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underrun_set got=%b required=1", p0_wr_underrun);
        end
        push_wr(wbuf_data[2], 4'b0000);
        push_wr(wbuf_data[3], 4'b0000);
        do_read(64, 4, I_RD, 1'b0);
        drain("underrun_readback");
        checks++;
        if (p0_wr_underrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underrun_sticky got=%b required=1", p0_wr_underrun);
        end
    endtask

    task automatic test_wrap();
        wbuf_data[0] = 32'hC0DE_0FFF; wbuf_mask[0] = 4'b0000;
        wbuf_data[1] = 32'hC0DE_0000; wbuf_mask[1] = 4'b0000;
        do_write(WORDS - 1, 2, I_WR, 1'b0);
        do_read(WORDS - 1, 2, I_RD, 1'b0);
        do_read(0, 1, I_RD, 1'b0);
        drain("wrap");
    endtask

    task automatic test_rd_full();
        for (int i = 0; i < 64; i++) begin
            wbuf_data[i] = $urandom;
            wbuf_mask[i] = 4'b0000;
        end
        do_write(256, 64, I_WR, 1'b0);
        do_read(256, 64, I_RD, 1'b0);
        repeat (150) tick();
        do_read(256, 2, I_RD, 1'b0);
        repeat (30) tick();
        checks++;
        if (p0_rd_overflow !== 1'b0 || p0_rd_empty !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rdfull_state got overflow=%b empty=%b required=0/0", p0_rd_overflow, p0_rd_empty);
        end
        drain("rdfull");
        tick();
        checks++;
        if (p0_rd_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rdfull_empty_after got=%b required=1", p0_rd_empty);
        end
        p0_rd_en = 1'b1;
        tick();
        p0_rd_en = 1'b0;
        checks++;
        if (p0_rd_overflow !== 1'b1 || p0_rd_empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_set got overflow=%b empty=%b required=1/1", p0_rd_overflow, p0_rd_empty);
        end
        last_wr_addr = 256;
        last_wr_n    = 64;
    endtask

    task automatic test_random();
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 3; j++) begin
                int op;
                op = $urandom_range(0, 3);
                if (op <= 1) begin
                    int a, n;
                    a = $urandom_range(0, WORDS - 1);
                    n = $urandom_range(1, 16);
                    for (int i = 0; i < n; i++) begin
                        wbuf_data[i] = $urandom;
                        wbuf_mask[i] = model_known[(a + i) % WORDS] ? 4'($urandom) : 4'b0000;
                    end
                    do_write(a, n, ($urandom % 2) ? I_WR_AP : I_WR, 1'b1);
                    last_wr_addr = a;
                    last_wr_n    = n;
                end else if (op == 2) begin
                    int off, n;
                    off = $urandom_range(0, last_wr_n - 1);
                    n   = $urandom_range(1, last_wr_n - off);
                    do_read((last_wr_addr + off) % WORDS, n, ($urandom % 2) ? I_RD_AP : I_RD, 1'b1);
                end else begin
                    push_cmd(3'($urandom_range(4, 7)), 30'($urandom), 6'($urandom));
                end
            end
            drain("random");
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i]   = 32'h0;
            model_known[i] = 1'b0;
        end
        $display("[TB] start");
        test_reset();
        test_basic();
        test_mask();
        test_latency();
        test_underrun();
        test_wrap();
        test_rd_full();
        test_random();
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
